// File: rtl/als_seq_if.sv
// Request/response bus of the ALU/shift sequencer: operands in with start,
// result and status flags out with the done pulse.
`timescale 1ns/1ps
interface als_seq_if;
  logic        start;
  logic [5:0]  instr_funct;
  logic [4:0]  shamt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;
  logic        illegal;

  // start is a request pulse, honoured only while busy is low; the same-cycle
  // operands are captured. done marks the single cycle in which result, ovf
  // and illegal first show the new values; they hold until the next done.
  modport master (
    output start, instr_funct, shamt, rs_val, rt_val,
    input  busy, done, result, ovf, illegal
  );
  modport slave (
    input  start, instr_funct, shamt, rs_val, rt_val,
    output busy, done, result, ovf, illegal
  );
endinterface

// File: rtl/als_seq.sv
// Sequencer for MIPS R-type ALU and shift instructions: decodes funct, drives
// an external combinational ALU or a clocked shift register, and registers the result.
`timescale 1ns/1ps
module als_seq (
  input  logic        Clk,
  input  logic        reset,
  als_seq_if.slave    bus,
  output logic        operation,
  output logic [2:0]  ALU_sel,
  output logic [31:0] oper_A,
  output logic [31:0] oper_B,
  input  logic [31:0] ALU_result,
  input  logic        overflow,
  input  logic        lesser,
  output logic [2:0]  sh_funct,
  output logic [4:0]  NumberofShifts,
  output logic [31:0] Array,
  input  logic [31:0] Shifted_Array,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ALU_EX  = 3'd1,
    S_SH_LOAD = 3'd2,
    S_SH_RUN  = 3'd3,
    S_SH_CAP  = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       is_shift;
    logic       var_amt;
    logic       ovf_en;
    logic       is_slt;
    logic [2:0] code;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] f);
    dec_t d;
    d       = '0;
    d.legal = 1'b1;
    case (f)
      6'h20: begin d.code = 3'b001; d.ovf_en = 1'b1; end
      6'h21: d.code = 3'b001;
      6'h22: begin d.code = 3'b010; d.ovf_en = 1'b1; end
      6'h23: d.code = 3'b010;
      6'h24: d.code = 3'b011;
      6'h26: d.code = 3'b110;
      6'h2A: begin d.code = 3'b111; d.is_slt = 1'b1; end
      6'h00: begin d.code = 3'b010; d.is_shift = 1'b1; end
      6'h02: begin d.code = 3'b011; d.is_shift = 1'b1; end
      6'h03: begin d.code = 3'b100; d.is_shift = 1'b1; end
      6'h04: begin d.code = 3'b010; d.is_shift = 1'b1; d.var_amt = 1'b1; end
      6'h06: begin d.code = 3'b011; d.is_shift = 1'b1; d.var_amt = 1'b1; end
      6'h07: begin d.code = 3'b100; d.is_shift = 1'b1; d.var_amt = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_e      state, state_nxt;
  logic [5:0]  funct_q;
  logic [31:0] rs_q, rt_q, result_q;
  logic [4:0]  amt_q;
  logic        ovf_q, ill_q;
  dec_t        in_dec, q_dec;

  assign in_dec = decode(bus.instr_funct);
  assign q_dec  = decode(funct_q);

  always_ff @(posedge Clk) begin
    if (reset) begin
      state    <= S_IDLE;
      funct_q  <= 6'h0;
      rs_q     <= 32'h0;
      rt_q     <= 32'h0;
      amt_q    <= 5'h0;
      result_q <= 32'h0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            funct_q <= bus.instr_funct;
            rs_q    <= bus.rs_val;
            rt_q    <= bus.rt_val;
            amt_q   <= in_dec.var_amt ? bus.rs_val[4:0] : bus.shamt;
            // Illegal requests skip execution, so their status lands now.
            if (!in_dec.legal) begin
              result_q <= 32'h0;
              ovf_q    <= 1'b0;
              ill_q    <= 1'b1;
            end
          end
        end
        S_ALU_EX: begin
          result_q <= q_dec.is_slt ? {31'b0, lesser} : ALU_result;
          ovf_q    <= q_dec.ovf_en & overflow;
          ill_q    <= 1'b0;
        end
        S_SH_CAP: begin
          result_q <= Shifted_Array;
          ovf_q    <= 1'b0;
          ill_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    operation = 1'b0;
    ALU_sel   = 3'b000;
    sh_funct  = 3'b000;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (!in_dec.legal)       state_nxt = S_DONE;
          else if (in_dec.is_shift) state_nxt = S_SH_LOAD;
          else                      state_nxt = S_ALU_EX;
        end
      end
      S_ALU_EX: begin
        ALU_sel   = q_dec.code;
        state_nxt = S_DONE;
      end
      S_SH_LOAD: begin
        operation = 1'b1;
        sh_funct  = 3'b001;
        state_nxt = S_SH_RUN;
      end
      S_SH_RUN: begin
        operation = 1'b1;
        sh_funct  = q_dec.code;
        state_nxt = S_SH_CAP;
      end
      S_SH_CAP: begin
        operation = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.result     = result_q;
  assign bus.ovf        = ovf_q;
  assign bus.illegal    = ill_q;
  assign oper_A         = rs_q;
  assign oper_B         = rt_q;
  assign Array          = rt_q;
  assign NumberofShifts = amt_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_als_seq.sv
// Bench for als_seq: behavioural ALU and shift-register stubs, a funct-level
// reference model, directed corner cases, random traffic and reset scenarios.
`timescale 1ns/1ps
module tb_als_seq;
  localparam int W = 38;  // {latency[3:0], illegal, ovf, result[31:0]}

  logic        Clk = 1'b0;
  logic        reset;
  logic        operation, overflow, lesser;
  logic [2:0]  ALU_sel, sh_funct, state_dbg;
  logic [31:0] oper_A, oper_B, ALU_result, Array, Shifted_Array, sh_reg;
  logic [4:0]  NumberofShifts;
  logic [31:0] sum_ab, dif_ab;

  logic [W-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  als_seq_if bus();

  als_seq dut (
    .Clk(Clk), .reset(reset), .bus(bus),
    .operation(operation), .ALU_sel(ALU_sel), .oper_A(oper_A), .oper_B(oper_B),
    .ALU_result(ALU_result), .overflow(overflow), .lesser(lesser),
    .sh_funct(sh_funct), .NumberofShifts(NumberofShifts), .Array(Array),
    .Shifted_Array(Shifted_Array), .state_dbg(state_dbg)
  );

  // ---------------- clock / environment stubs ----------------
  always #5 Clk = ~Clk;

  assign sum_ab = oper_A + oper_B;
  assign dif_ab = oper_A - oper_B;
  assign lesser = ($signed(oper_A) < $signed(oper_B));

  always_comb begin
    ALU_result = 32'h0;
    overflow   = 1'b0;
    case (ALU_sel)
      3'b001: begin
        ALU_result = sum_ab;
        overflow   = (oper_A[31] == oper_B[31]) && (sum_ab[31] != oper_A[31]);
      end
      3'b010: begin
        ALU_result = dif_ab;
        overflow   = (oper_A[31] != oper_B[31]) && (dif_ab[31] != oper_A[31]);
      end
      3'b011:  ALU_result = oper_A & oper_B;
      3'b110:  ALU_result = oper_A ^ oper_B;
      3'b111:  ALU_result = dif_ab;
      default: ALU_result = 32'h0;
    endcase
  end

  always @(posedge Clk) begin
    case (sh_funct)
      3'b001:  sh_reg <= Array;
      3'b010:  sh_reg <= sh_reg << NumberofShifts;
      3'b011:  sh_reg <= sh_reg >> NumberofShifts;
      3'b100:  sh_reg <= $signed(sh_reg) >>> NumberofShifts;
      default: sh_reg <= sh_reg;
    endcase
  end
  assign Shifted_Array = sh_reg;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_model(input logic [5:0] f, input logic [4:0] sa,
                                              input logic [31:0] rs, input logic [31:0] rt);
    longint a, b, s;
    logic [31:0] r;
    logic o, il;
    int lat;
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    s = 0; r = 32'h0; o = 1'b0; il = 1'b0; lat = 2;
    case (f)
      6'h20, 6'h21: begin
        s = a + b; r = s[31:0];
        o = (f == 6'h20) && (s != longint'($signed(r)));
      end
      6'h22, 6'h23: begin
        s = a - b; r = s[31:0];
        o = (f == 6'h22) && (s != longint'($signed(r)));
      end
      6'h24: r = rs & rt;
      6'h26: r = rs ^ rt;
      6'h2A: r = (a < b) ? 32'd1 : 32'd0;
      6'h00: begin r = rt << sa; lat = 4; end
      6'h02: begin r = rt >> sa; lat = 4; end
      6'h03: begin r = $signed(rt) >>> sa; lat = 4; end
      6'h04: begin r = rt << rs[4:0]; lat = 4; end
      6'h06: begin r = rt >> rs[4:0]; lat = 4; end
      6'h07: begin r = $signed(rt) >>> rs[4:0]; lat = 4; end
      default: begin il = 1'b1; lat = 1; end
    endcase
    return {4'(lat), il, o, r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge Clk);
    while (bus.busy && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
  endtask

  task automatic drive_req(input logic [5:0] f, input logic [4:0] sa,
                           input logic [31:0] rs, input logic [31:0] rt);
    bus.start       = 1'b1;
    bus.instr_funct = f;
    bus.shamt       = sa;
    bus.rs_val      = rs;
    bus.rt_val      = rt;
  endtask

  task automatic scramble_inputs();
    bus.start       = 1'b0;
    bus.instr_funct = 6'($urandom());
    bus.shamt       = 5'($urandom());
    bus.rs_val      = $urandom();
    bus.rt_val      = $urandom();
  endtask

  // Issues one request and returns {latency, illegal, ovf, result}; latency 15 = no done.
  task automatic run_op(input logic [5:0] f, input logic [4:0] sa, input logic [31:0] rs,
                        input logic [31:0] rt, output logic [W-1:0] obs);
    int lat;
    wait_idle();
    drive_req(f, sa, rs, rt);
    @(posedge Clk); #1;
    scramble_inputs();
    lat = 1;
    while (!bus.done && lat < 10) begin
      @(posedge Clk); #1;
      lat++;
    end
    obs = {(bus.done ? 4'(lat) : 4'hF), bus.illegal, bus.ovf, bus.result};
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.instr_funct = 6'h0; bus.shamt = 5'h0;
    bus.rs_val = 32'h0; bus.rt_val = 32'h0;
    repeat (3) @(posedge Clk);
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.ovf, bus.illegal, operation, sh_funct, ALU_sel} !== 11'h0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got busy/done/ovf/ill/op/sh/alu %b, expected all zero",
               {bus.busy, bus.done, bus.ovf, bus.illegal, operation, sh_funct, ALU_sel});
    end
    tests_run++;
    if (bus.result !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_result: got %h, expected 00000000", bus.result);
    end
    tests_run++;
    if ({oper_A, oper_B, NumberofShifts} !== 69'h0) begin
      tests_failed++;
      $display("FAIL reset_operands: got A=%h B=%h n=%0d, expected zero", oper_A, oper_B, NumberofShifts);
    end
    @(negedge Clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [5:0]  fs[10]  = '{6'h20, 6'h21, 6'h22, 6'h04, 6'h03, 6'h3F, 6'h00, 6'h2A, 6'h06, 6'h24};
    logic [4:0]  sas[10] = '{5'd0, 5'd0, 5'd0, 5'd17, 5'd4, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0};
    logic [31:0] rss[10] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000023, 32'h0,
                             32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h0000001F, 32'hF0F0F0F0};
    logic [31:0] rts[10] = '{32'h1, 32'h1, 32'h1, 32'h00000001, 32'h80000010,
                             32'h9ABCDEF0, 32'hDEADBEEF, 32'h1, 32'h80000000, 32'h3C3C3C3C};
    logic [W-1:0] obs, exp_v;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(ref_model(fs[i], sas[i], rss[i], rts[i]));
      run_op(fs[i], sas[i], rss[i], rts[i], obs);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL directed[%0d] funct=%h: got lat/ill/ovf/result %h, expected %h",
                 i, fs[i], obs, exp_v);
      end
    end
  endtask

  task automatic test_drive_lines();
    logic [2:0] sh_exp[3] = '{3'b001, 3'b100, 3'b000};
    logic [31:0] a;
    // sra sequence: load, shift, hold, then done
    wait_idle();
    drive_req(6'h03, 5'd4, 32'h0, 32'h80000010);
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      scramble_inputs();
      tests_run++;
      if ({sh_funct, ALU_sel, operation, bus.busy, bus.done} !== {sh_exp[c], 3'b000, 3'b110}) begin
        tests_failed++;
        $display("FAIL sra_seq[%0d]: got sh/alu/op/busy/done %b, expected %b",
                 c, {sh_funct, ALU_sel, operation, bus.busy, bus.done}, {sh_exp[c], 3'b000, 3'b110});
      end
    end
    @(posedge Clk); #1;
    tests_run++;
    if ({bus.done, bus.busy, sh_funct, ALU_sel, bus.result} !== {2'b11, 6'b0, 32'hF8000001}) begin
      tests_failed++;
      $display("FAIL sra_done: got done/busy/sh/alu/result %h, expected %h",
               {bus.done, bus.busy, sh_funct, ALU_sel, bus.result}, {2'b11, 6'b0, 32'hF8000001});
    end
    // ALU execute cycle drives ALU_sel and the captured operands
    a = $urandom();
    wait_idle();
    drive_req(6'h20, 5'd0, a, 32'h5);
    @(posedge Clk); #1;
    scramble_inputs();
    tests_run++;
    if ({ALU_sel, sh_funct, operation, oper_A, oper_B} !== {3'b001, 3'b000, 1'b0, a, 32'h5}) begin
      tests_failed++;
      $display("FAIL alu_drive: got sel=%b sh=%b op=%b A=%h B=%h, expected sel=001 sh=000 op=0 A=%h B=00000005",
               ALU_sel, sh_funct, operation, oper_A, oper_B, a);
    end
  endtask

  task automatic test_random();
    logic [5:0] legal_f[13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h26, 6'h2A,
                                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0]  f;
    logic [4:0]  sa;
    logic [31:0] rs, rt;
    logic [W-1:0] obs, exp_v;
    for (int i = 0; i < 150; i++) begin
      f  = ($urandom_range(0, 5) == 0) ? 6'($urandom()) : legal_f[$urandom_range(0, 12)];
      sa = 5'($urandom());
      rs = pick_operand();
      rt = pick_operand();
      exp_q.push_back(ref_model(f, sa, rs, rt));
      run_op(f, sa, rs, rt, obs);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL random[%0d] funct=%h sa=%0d rs=%h rt=%h: got %h, expected %h",
                 i, f, sa, rs, rt, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rs, rt;
    logic [W-1:0] obs, exp_v;
    int lat;
    wait_idle();
    drive_req(6'h03, 5'd4, 32'h0, 32'h80000010);
    @(posedge Clk); #1;
    scramble_inputs();
    @(posedge Clk); #1;
    tests_run++;
    if ({sh_funct, bus.done} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL abort_in_run: got sh/done %b, expected 1000", {sh_funct, bus.done});
    end
    // reset arrives together with a start; reset must win
    @(negedge Clk);
    reset = 1'b1;
    drive_req(6'h3F, 5'd0, 32'h1, 32'h1);
    @(posedge Clk); #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.illegal, sh_funct, bus.result} !== 38'h0) begin
      tests_failed++;
      $display("FAIL abort_reset: got busy/done/ill/sh/result %h, expected 0",
               {bus.busy, bus.done, bus.illegal, sh_funct, bus.result});
    end
    @(negedge Clk);
    reset = 1'b0;
    rs = pick_operand();
    rt = pick_operand();
    exp_q.push_back(ref_model(6'h22, 5'd0, rs, rt));
    drive_req(6'h22, 5'd0, rs, rt);
    @(posedge Clk); #1;
    scramble_inputs();
    lat = 1;
    while (!bus.done && lat < 10) begin
      @(posedge Clk); #1;
      lat++;
    end
    obs   = {(bus.done ? 4'(lat) : 4'hF), bus.illegal, bus.ovf, bus.result};
    exp_v = exp_q.pop_front();
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL after_reset_start: got %h, expected %h", obs, exp_v);
    end
  endtask

  task automatic test_start_held();
    logic [31:0] rs, rt;
    logic [W-1:0] ref_v;
    logic [1:0] exp_bd;
    rs = pick_operand();
    rt = pick_operand();
    ref_v = ref_model(6'h21, 5'd0, rs, rt);
    wait_idle();
    drive_req(6'h21, 5'd0, rs, rt);
    @(posedge Clk); #1;
    // with start held, the sequence is ALU_EX, DONE, IDLE(accept) repeating
    for (int k = 0; k < 30; k++) begin
      case (k % 3)
        0:       exp_bd = 2'b10;
        1:       exp_bd = 2'b11;
        default: exp_bd = 2'b00;
      endcase
      tests_run++;
      if ({bus.busy, bus.done} !== exp_bd) begin
        tests_failed++;
        $display("FAIL start_held[%0d]: got busy/done %b, expected %b", k, {bus.busy, bus.done}, exp_bd);
      end
      if (k % 3 == 1) begin
        tests_run++;
        if (bus.result !== ref_v[31:0]) begin
          tests_failed++;
          $display("FAIL start_held_result[%0d]: got %h, expected %h", k, bus.result, ref_v[31:0]);
        end
      end
      if (k == 29) bus.start = 1'b0;
      else begin
        @(posedge Clk); #1;
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_directed();
    test_drive_lines();
    test_random();
    test_reset_abort();
    test_start_held();
    repeat (3) @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
